// File: rtl/pcie_user_regs_mc.sv
// BAR0 user-register file: local IPv4/MAC plus NCH destination channels with shadow/live
// staging, per-channel transmit counters, a commit sequencer and a pipelined read port.
module pcie_user_regs_mc #(
   parameter int unsigned NCH    = 4,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              sys_rst_n,
   input  logic [13:0]       rd_addr,
   input  logic [3:0]        rd_be,
   output logic [31:0]       rd_data,
   input  logic [13:0]       wr_addr,
   input  logic [7:0]        wr_be,
   input  logic [31:0]       wr_data,
   input  logic              wr_en,
   output logic              wr_busy,
   input  logic [NCH-1:0]    tx_pulse,
   input  logic [7:0]        debug,
   output logic [31:0]       if_v4addr,
   output logic [47:0]       if_macaddr,
   output logic [NCH*32-1:0] dest_v4addr,
   output logic [NCH*48-1:0] dest_macaddr,
   output logic [NCH*36-1:0] mem_paddr
);

   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [31:0] RST_IF_V4   = 32'h0A00_15C7;
   localparam logic [47:0] RST_IF_MAC  = 48'h0037_7600_0001;
   localparam logic [31:0] RST_DST_V4  = 32'h0A00_15FF;
   localparam logic [47:0] RST_DST_MAC = 48'hFFFF_FFFF_FFFF;
   localparam logic [35:0] RST_PADDR   = 36'h0_000D_0000;
   localparam logic [7:0]  NCH_ID      = 8'(NCH);

   typedef enum logic [0:0] {StIdle, StCopy} state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [15:0]         commit_cnt_q, commit_cnt_d;
   logic [31:0]         if_v4_q, if_v4_d;
   logic [47:0]         if_mac_q, if_mac_d;
   logic [NCH-1:0][31:0] sh_v4_q, sh_v4_d, live_v4_q, live_v4_d;
   logic [NCH-1:0][47:0] sh_mac_q, sh_mac_d, live_mac_q, live_mac_d;
   logic [NCH-1:0][35:0] sh_pa_q, sh_pa_d, live_pa_q, live_pa_d;
   logic [NCH*32-1:0]   tx_cnt_q, tx_cnt_d;
   logic [31:0]         rd_mux, rd_q1;
   logic                commit_req;
   logic [31:0]         wr_tmp, cnt;
   logic                clr;

   // Lane 0 is the most significant byte on this bus.
   function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old;
      if (be[0]) r[31:24] = nw[31:24];
      if (be[1]) r[23:16] = nw[23:16];
      if (be[2]) r[15:8]  = nw[15:8];
      if (be[3]) r[7:0]   = nw[7:0];
      return r;
   endfunction

   logic [6:0] wr_off, rd_off;
   logic [3:0] wr_chsel, rd_chsel;
   logic       wr_ok, wr_ch_ok, rd_ch_ok;

   assign wr_off   = wr_addr[6:0];
   assign rd_off   = rd_addr[6:0];
   assign wr_chsel = wr_off[6:3] - 4'd2;
   assign rd_chsel = rd_off[6:3] - 4'd2;
   assign wr_ok    = wr_en && !wr_busy && (wr_addr[13:12] == 2'b01);
   assign wr_ch_ok = (wr_off[6:4] != 3'd0) && ({28'd0, wr_chsel} < NCH);
   assign rd_ch_ok = (rd_off[6:4] != 3'd0) && ({28'd0, rd_chsel} < NCH);

   assign wr_busy = (state_q == StCopy);

   always_comb begin
      if_v4_d    = if_v4_q;
      if_mac_d   = if_mac_q;
      sh_v4_d    = sh_v4_q;
      sh_mac_d   = sh_mac_q;
      sh_pa_d    = sh_pa_q;
      tx_cnt_d   = tx_cnt_q;
      commit_req = 1'b0;
      wr_tmp     = '0;
      cnt        = '0;
      clr        = 1'b0;
      if (wr_ok && !wr_ch_ok) begin
         case (wr_off)
            7'h00: if_v4_d = be_merge(if_v4_q, wr_data, wr_be[3:0]);
            7'h02: if_mac_d[47:16] = be_merge(if_mac_q[47:16], wr_data, wr_be[3:0]);
            7'h03: begin
               wr_tmp = be_merge({if_mac_q[15:0], 16'h0}, wr_data, wr_be[3:0]);
               if_mac_d[15:0] = wr_tmp[31:16];
            end
            7'h05: commit_req = wr_be[3] && wr_data[0];
            default: ;
         endcase
      end
      for (int i = 0; i < NCH; i++) begin
         clr = 1'b0;
         if (wr_ok && wr_ch_ok && (wr_chsel == 4'(i))) begin
            case (wr_off[2:0])
               3'd0: sh_v4_d[i] = be_merge(sh_v4_q[i], wr_data, wr_be[3:0]);
               3'd2: sh_mac_d[i][47:16] = be_merge(sh_mac_q[i][47:16], wr_data, wr_be[3:0]);
               3'd3: begin
                  wr_tmp = be_merge({sh_mac_q[i][15:0], 16'h0}, wr_data, wr_be[3:0]);
                  sh_mac_d[i][15:0] = wr_tmp[31:16];
               end
               3'd4: begin
                  wr_tmp = be_merge({sh_pa_q[i][19:0], 12'h0}, wr_data, wr_be[3:0]);
                  sh_pa_d[i][19:0] = wr_tmp[31:12];
               end
               3'd5: begin
                  wr_tmp = be_merge({sh_pa_q[i][35:20], 16'h0}, wr_data, wr_be[3:0]);
                  sh_pa_d[i][35:20] = wr_tmp[31:16];
               end
               3'd6: clr = (wr_be[3:0] != 4'h0);
               default: ;
            endcase
         end
         // A clear coincident with a pulse counts that pulse.
         cnt = tx_cnt_q[32*i +: 32];
         if (clr) begin
            cnt = tx_pulse[i] ? 32'd1 : 32'd0;
         end else if (tx_pulse[i] && (cnt != 32'hFFFF_FFFF)) begin
            cnt = cnt + 32'd1;
         end
         tx_cnt_d[32*i +: 32] = cnt;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      commit_cnt_d = commit_cnt_q;
      live_v4_d    = live_v4_q;
      live_mac_d   = live_mac_q;
      live_pa_d    = live_pa_q;
      unique case (state_q)
         StIdle: begin
            if (commit_req) begin
               state_d = StCopy;
               idx_d   = '0;
            end
         end
         StCopy: begin
            for (int i = 0; i < NCH; i++) begin
               if (idx_q == IW'(i)) begin
                  live_v4_d[i]  = sh_v4_q[i];
                  live_mac_d[i] = sh_mac_q[i];
                  live_pa_d[i]  = sh_pa_q[i];
               end
            end
            if (idx_q == IW'(NCH - 1)) begin
               state_d      = StIdle;
               commit_cnt_d = commit_cnt_q + 16'd1;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         commit_cnt_q <= '0;
         if_v4_q      <= RST_IF_V4;
         if_mac_q     <= RST_IF_MAC;
         sh_v4_q      <= {NCH{RST_DST_V4}};
         sh_mac_q     <= {NCH{RST_DST_MAC}};
         sh_pa_q      <= {NCH{RST_PADDR}};
         live_v4_q    <= {NCH{RST_DST_V4}};
         live_mac_q   <= {NCH{RST_DST_MAC}};
         live_pa_q    <= {NCH{RST_PADDR}};
         tx_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         commit_cnt_q <= commit_cnt_d;
         if_v4_q      <= if_v4_d;
         if_mac_q     <= if_mac_d;
         sh_v4_q      <= sh_v4_d;
         sh_mac_q     <= sh_mac_d;
         sh_pa_q      <= sh_pa_d;
         live_v4_q    <= live_v4_d;
         live_mac_q   <= live_mac_d;
         live_pa_q    <= live_pa_d;
         tx_cnt_q     <= tx_cnt_d;
      end
   end

   // Reads see pre-edge state, so a same-cycle write to the same offset is not visible.
   always_comb begin
      rd_mux = '0;
      if (rd_addr[13:12] == 2'b01) begin
         if (rd_ch_ok) begin
            for (int i = 0; i < NCH; i++) begin
               if (rd_chsel == 4'(i)) begin
                  case (rd_off[2:0])
                     3'd0: rd_mux = sh_v4_q[i];
                     3'd2: rd_mux = sh_mac_q[i][47:16];
                     3'd3: rd_mux = {sh_mac_q[i][15:0], 16'h0};
                     3'd4: rd_mux = {sh_pa_q[i][19:0], 12'h0};
                     3'd5: rd_mux = {sh_pa_q[i][35:20], 16'h0};
                     3'd6: rd_mux = tx_cnt_q[32*i +: 32];
                     default: rd_mux = '0;
                  endcase
               end
            end
         end else begin
            case (rd_off)
               7'h00: rd_mux = if_v4_q;
               7'h02: rd_mux = if_mac_q[47:16];
               7'h03: rd_mux = {if_mac_q[15:0], 8'h00, debug};
               7'h04: rd_mux = {8'h02, 16'h0000, NCH_ID};
               7'h06: rd_mux = {commit_cnt_q, 15'h0, wr_busy};
               default: rd_mux = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rd_q1 <= '0;
      else            rd_q1 <= rd_mux;
   end

   if (RD_LAT >= 2) begin : g_rd_lat2
      logic [31:0] rd_q2;
      always_ff @(posedge clk or negedge sys_rst_n) begin
         if (!sys_rst_n) rd_q2 <= '0;
         else            rd_q2 <= rd_q1;
      end
      assign rd_data = rd_q2;
   end else begin : g_rd_lat1
      assign rd_data = rd_q1;
   end

   assign if_v4addr    = if_v4_q;
   assign if_macaddr   = if_mac_q;
   assign dest_v4addr  = live_v4_q;
   assign dest_macaddr = live_mac_q;
   assign mem_paddr    = live_pa_q;

   logic unused_ok;
   assign unused_ok = ^{rd_be, wr_be[7:4], rd_addr[11:7], wr_addr[11:7]};

endmodule

// File: tb/tb_pcie_user_regs_mc.sv
// Randomized bench for pcie_user_regs_mc against a register-map model; a second instance
// built with RD_LAT=2 shares all inputs.
module tb_pcie_user_regs_mc;

   localparam int NCH = 4;

   logic              clk = 1'b0;
   logic              sys_rst_n;
   logic [13:0]       rd_addr, wr_addr;
   logic [3:0]        rd_be;
   logic [7:0]        wr_be, debug;
   logic [31:0]       wr_data;
   logic              wr_en;
   logic [NCH-1:0]    tx_pulse;
   logic [31:0]       rd_data, rd_data2, if_v4addr, if_v4addr2;
   logic              wr_busy, wr_busy2;
   logic [47:0]       if_macaddr, if_macaddr2;
   logic [NCH*32-1:0] dest_v4addr, dest_v4addr2;
   logic [NCH*48-1:0] dest_macaddr, dest_macaddr2;
   logic [NCH*36-1:0] mem_paddr, mem_paddr2;

   pcie_user_regs_mc #(.NCH(NCH), .RD_LAT(1)) dut (
      .clk(clk), .sys_rst_n(sys_rst_n), .rd_addr(rd_addr), .rd_be(rd_be), .rd_data(rd_data),
      .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy),
      .tx_pulse(tx_pulse), .debug(debug), .if_v4addr(if_v4addr), .if_macaddr(if_macaddr),
      .dest_v4addr(dest_v4addr), .dest_macaddr(dest_macaddr), .mem_paddr(mem_paddr)
   );

   pcie_user_regs_mc #(.NCH(NCH), .RD_LAT(2)) dut2 (
      .clk(clk), .sys_rst_n(sys_rst_n), .rd_addr(rd_addr), .rd_be(rd_be), .rd_data(rd_data2),
      .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy2),
      .tx_pulse(tx_pulse), .debug(debug), .if_v4addr(if_v4addr2), .if_macaddr(if_macaddr2),
      .dest_v4addr(dest_v4addr2), .dest_macaddr(dest_macaddr2), .mem_paddr(mem_paddr2)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: registers held as plain values, paddr as a full 48-bit address.
   logic [31:0] m_if_v4;
   logic [47:0] m_if_mac;
   logic [31:0] m_sh_v4 [NCH], m_live_v4 [NCH];
   logic [47:0] m_sh_mac [NCH], m_live_mac [NCH];
   logic [47:0] m_sh_pa [NCH], m_live_pa [NCH];
   logic [31:0] m_tx [NCH];
   int          m_commits;
   int          m_busy_left;
   logic [31:0] exp_rd1, exp_rd2;

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] be);
      logic [31:0] r = old;
      for (int k = 0; k < 4; k++) if (be[k]) r[31-8*k -: 8] = nw[31-8*k -: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_if_v4 = 32'h0A00_15C7;
      m_if_mac = 48'h0037_7600_0001;
      for (int n = 0; n < NCH; n++) begin
         m_sh_v4[n] = 32'h0A00_15FF;  m_live_v4[n] = 32'h0A00_15FF;
         m_sh_mac[n] = '1;            m_live_mac[n] = '1;
         m_sh_pa[n] = 48'h0000_D000_0000; m_live_pa[n] = 48'h0000_D000_0000;
         m_tx[n] = 0;
      end
      m_commits = 0;
      m_busy_left = 0;
      exp_rd1 = 0;
      exp_rd2 = 0;
   endtask

   function automatic logic [31:0] model_read(input logic [13:0] a);
      int off, ch, sub;
      logic [7:0] nch8 = 8'(NCH);
      logic [15:0] cc = 16'(m_commits);
      if (a[13:12] != 2'b01) return 32'h0;
      off = int'(a[6:0]);
      if (off < 16) begin
         case (off)
            0: return m_if_v4;
            2: return m_if_mac[47:16];
            3: return {m_if_mac[15:0], 8'h00, debug};
            4: return {8'h02, 16'h0, nch8};
            6: return {cc, 15'h0, (m_busy_left != 0)};
            default: return 32'h0;
         endcase
      end
      ch = (off - 16) / 8;
      sub = off % 8;
      if (ch >= NCH) return 32'h0;
      case (sub)
         0: return m_sh_v4[ch];
         2: return m_sh_mac[ch][47:16];
         3: return {m_sh_mac[ch][15:0], 16'h0};
         4: return m_sh_pa[ch][31:0];
         5: return {m_sh_pa[ch][47:32], 16'h0};
         6: return m_tx[ch];
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic [31:0] t;
      logic [NCH-1:0] clr = '0;
      bit commit_now = 0;
      int off, ch, sub;
      exp_rd2 = exp_rd1;
      exp_rd1 = model_read(rd_addr);
      if (wr_en && m_busy_left == 0 && wr_addr[13:12] == 2'b01) begin
         off = int'(wr_addr[6:0]);
         if (off < 16) begin
            case (off)
               0: m_if_v4 = lane_merge(m_if_v4, wr_data, wr_be[3:0]);
               2: m_if_mac[47:16] = lane_merge(m_if_mac[47:16], wr_data, wr_be[3:0]);
               3: begin
                  t = lane_merge({m_if_mac[15:0], 16'h0}, wr_data, wr_be[3:0]);
                  m_if_mac[15:0] = t[31:16];
               end
               5: commit_now = wr_be[3] && wr_data[0];
               default: ;
            endcase
         end else begin
            ch = (off - 16) / 8;
            sub = off % 8;
            if (ch < NCH) begin
               case (sub)
                  0: m_sh_v4[ch] = lane_merge(m_sh_v4[ch], wr_data, wr_be[3:0]);
                  2: m_sh_mac[ch][47:16] = lane_merge(m_sh_mac[ch][47:16], wr_data, wr_be[3:0]);
                  3: begin
                     t = lane_merge({m_sh_mac[ch][15:0], 16'h0}, wr_data, wr_be[3:0]);
                     m_sh_mac[ch][15:0] = t[31:16];
                  end
                  4: begin
                     t = lane_merge(m_sh_pa[ch][31:0], wr_data, wr_be[3:0]);
                     m_sh_pa[ch][31:0] = {t[31:12], 12'h0};
                  end
                  5: begin
                     t = lane_merge({m_sh_pa[ch][47:32], 16'h0}, wr_data, wr_be[3:0]);
                     m_sh_pa[ch][47:32] = t[31:16];
                  end
                  6: clr[ch] = (wr_be[3:0] != 4'h0);
                  default: ;
               endcase
            end
         end
      end
      for (int n = 0; n < NCH; n++) begin
         if (clr[n]) m_tx[n] = tx_pulse[n] ? 32'd1 : 32'd0;
         else if (tx_pulse[n] && m_tx[n] != 32'hFFFF_FFFF) m_tx[n] = m_tx[n] + 1;
      end
      // The whole copy is observed as one event at the end of the busy window.
      if (m_busy_left > 0) begin
         m_busy_left--;
         if (m_busy_left == 0) begin
            for (int n = 0; n < NCH; n++) begin
               m_live_v4[n] = m_sh_v4[n];
               m_live_mac[n] = m_sh_mac[n];
               m_live_pa[n] = m_sh_pa[n];
            end
            m_commits = (m_commits + 1) % 65536;
         end
      end
      if (commit_now) m_busy_left = NCH;
   endtask

   task automatic check_live(input string tag);
      for (int n = 0; n < NCH; n++) begin
         check({tag, "_v4"}, 64'(dest_v4addr[32*n +: 32]), 64'(m_live_v4[n]));
         check({tag, "_mac"}, 64'(dest_macaddr[48*n +: 48]), 64'(m_live_mac[n]));
         check({tag, "_pa"}, 64'(mem_paddr[36*n +: 36]), 64'(m_live_pa[n][47:12]));
      end
   endtask

   task automatic compare_all();
      check("busy", 64'(wr_busy), 64'(m_busy_left != 0));
      check("busy_lat2", 64'(wr_busy2), 64'(m_busy_left != 0));
      check("rd_lat1", 64'(rd_data), 64'(exp_rd1));
      check("rd_lat2", 64'(rd_data2), 64'(exp_rd2));
      check("if_v4", 64'(if_v4addr), 64'(m_if_v4));
      check("if_mac", 64'(if_macaddr), 64'(m_if_mac));
      if (m_busy_left == 0) check_live("live");
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wr(input logic [13:0] a, input logic [7:0] be, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [13:0] a);
      rd_addr = a;
      tick();
   endtask

   logic [NCH*32-1:0] fv;
   logic [31:0]       st0;
   int                nb;

   initial begin
      wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0; rd_addr = 0; rd_be = 4'hF;
      tx_pulse = '0; debug = 8'h5A; sys_rst_n = 1'b0;
      model_reset();
      #12;
      compare_all();
      check("rst_rd", 64'(rd_data), 64'h0);
      @(negedge clk);
      sys_rst_n = 1'b1;

      rd(14'h1000); check("id_v4", 64'(rd_data), 64'h0A00_15C7);
      rd(14'h1002); check("id_mac_hi", 64'(rd_data), 64'h0037_7600);
      rd(14'h1003); check("id_mac_lo", 64'(rd_data), 64'h0001_005A);
      rd(14'h1004); check("id_reg", 64'(rd_data), 64'h0200_0004);
      check("lat2_edge1", 64'(rd_data2), 64'h0001_005A);
      tick();       check("lat2_edge2", 64'(rd_data2), 64'h0200_0004);

      // Shadow write then commit on channel 2
      wr(14'h1020, 8'h0F, 32'hC0A8_0101);
      rd(14'h1020); check("ch2_shadow", 64'(rd_data), 64'hC0A8_0101);
      check("ch2_live_old", 64'(dest_v4addr[95:64]), 64'h0A00_15FF);
      wr(14'h1005, 8'h08, 32'h1);
      nb = 0;
      for (int i = 0; i < 10; i++) begin
         if (wr_busy) nb++;
         tick();
      end
      check("busy_cycles", 64'(nb), 64'd4);
      check("ch2_live_new", 64'(dest_v4addr[95:64]), 64'hC0A8_0101);
      rd(14'h1006); check("status_1", 64'(rd_data), 64'h0001_0000);

      // Partial byte-lane write
      wr(14'h1012, 8'h02, 32'h00AB_0000);
      rd(14'h1012); check("ch0_mac_hi", 64'(rd_data), 64'hFFAB_FFFF);
      rd(14'h1013); check("ch0_mac_lo", 64'(rd_data), 64'hFFFF_0000);

      // Writes and a second commit during COPY are dropped
      rd(14'h1006); st0 = rd_data;
      wr(14'h1005, 8'h08, 32'h1);
      wr(14'h1000, 8'h0F, 32'h0102_0304);
      wr(14'h1005, 8'h08, 32'h1);
      for (int i = 0; i < 6; i++) tick();
      check("busy_write_ign", 64'(if_v4addr), 64'h0A00_15C7);
      rd(14'h1006); check("status_once", 64'(rd_data), 64'({st0[31:16] + 16'd1, 16'h0}));

      // tx counter, clear coincident with pulse, saturation
      tx_pulse = 4'b0010;
      for (int i = 0; i < 3; i++) tick();
      tx_pulse = '0;
      rd(14'h101E); check("tx_three", 64'(rd_data), 64'd3);
      tx_pulse = 4'b0010;
      wr(14'h101E, 8'h01, 32'h0);
      tx_pulse = '0;
      rd(14'h101E); check("tx_clr_pulse", 64'(rd_data), 64'd1);
      for (int n = 0; n < NCH; n++) fv[32*n +: 32] = m_tx[n];
      fv[63:32] = 32'hFFFF_FFFD;
      m_tx[1] = 32'hFFFF_FFFD;
      force dut.tx_cnt_q = fv;
      force dut2.tx_cnt_q = fv;
      tick();
      release dut.tx_cnt_q;
      release dut2.tx_cnt_q;
      tx_pulse = 4'b0010;
      for (int i = 0; i < 5; i++) tick();
      tx_pulse = '0;
      rd(14'h101E); check("tx_sat", 64'(rd_data), 64'hFFFF_FFFF);

      // Reset in the middle of a commit
      wr(14'h1028, 8'h0F, 32'h1122_3344);
      wr(14'h1005, 8'h08, 32'h1);
      tick();
      #2 sys_rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_mid_busy", 64'(wr_busy), 64'd0);
      check("rst_mid_busy2", 64'(wr_busy2), 64'd0);
      check("rst_mid_ch2", 64'(dest_v4addr[95:64]), 64'h0A00_15FF);
      check_live("rst_mid");
      @(negedge clk);
      @(negedge clk);
      sys_rst_n = 1'b1;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         wr_en = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 9) == 0) wr_addr = 14'($urandom);
         else wr_addr = {7'b0100000, 7'($urandom_range(0, 8'h37))};
         wr_be = 8'($urandom);
         wr_data = $urandom;
         if ($urandom_range(0, 39) == 0) begin
            wr_addr = 14'h1005; wr_be = 8'h08; wr_data = 32'h1;
         end
         if ($urandom_range(0, 9) == 0) rd_addr = 14'($urandom);
         else rd_addr = {7'b0100000, 7'($urandom_range(0, 8'h37))};
         tx_pulse = NCH'($urandom);
         debug = 8'($urandom);
         tick();
      end
      wr_en = 1'b0;
      tx_pulse = '0;
      for (int i = 0; i < 2 * NCH; i++) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pcie_user_regs_mc.md
Name: pcie_user_regs_mc

Overview:
- Multi-channel successor to the BAR0 user-register file behind the PIO endpoint.
- Holds the local interface identity (IPv4/MAC) plus NCH remote destination channels, each with IPv4, MAC and remote memory physical page address.
- Channel writes land in shadow registers and are copied to live outputs atomically by a commit sequence.
- Adds per-channel transmit counters, a pipelined read path and a real wr_busy handshake.

Parameters:
- NCH, 4, number of destination channels, legal 1..8.
- RD_LAT, 1, read latency in clk cycles, legal 1 or 2.

Ports:
- clk  in  1  PCIe user clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  14  dword read address.
- rd_be  in  4  read byte enable; ignored, full dword always returned.
- rd_data  out  32  read data.
- wr_addr  in  14  dword write address.
- wr_be  in  8  write byte enable; only [3:0] used.
- wr_data  in  32  write data.
- wr_en  in  1  write strobe, one cycle per dword.
- wr_busy  out  1  commit in progress; writer must hold off.
- tx_pulse  in  NCH  one-cycle per-channel packet-sent event.
- debug  in  8  status byte, readable.
- if_v4addr  out  32  local IPv4 address.
- if_macaddr  out  48  local MAC address.
- dest_v4addr  out  NCH*32  live destination IPv4; channel n occupies [32n+31:32n].
- dest_macaddr  out  NCH*48  live destination MAC; channel n occupies [48n+47:48n].
- mem_paddr  out  NCH*36  live remote physical address bits [47:12] per channel.

Behaviour:
- Decode region: an access decodes only when addr[13:12]==2'b01. Other regions read 0 and ignore writes. Offset = addr[6:0].
- Byte lanes: wr_be[0] writes bits 31:24, wr_be[1] 23:16, wr_be[2] 15:8, wr_be[3] 7:0.
- Global map:
  - 0x00 if_v4addr (RW).
  - 0x02 if_mac[47:16] (RW).
  - 0x03 {if_mac[15:0], 8'h00, debug} (RW upper two bytes).
  - 0x04 ID (RO) = {8'h02, 8'h00, 8'h00, NCH[7:0]}.
  - 0x05 CTRL: writing bit0=1 with wr_be[3] set starts a commit; reads 0.
  - 0x06 STATUS (RO) = {commit_cnt[15:0], 15'h0, busy}.
- Channel map, base 0x10+8n:
  - +0 dest_v4addr.
  - +2 mac[47:16].
  - +3 {mac[15:0], 16'h0}.
  - +4 {paddr[31:12], 12'h0}; bits 11:0 are RO 0.
  - +5 {paddr[47:32], 16'h0}.
  - +6 tx_cnt (RO; any write with a nonzero wr_be[3:0] clears it).
  - +1/+7 read 0.
  - Channel offsets for n>=NCH read 0 and ignore writes.
- Global registers update the cycle after wr_en. Channel writes update shadow only; channel reads return shadow values.
- Commit FSM, IDLE -> COPY -> IDLE:
  - The commit write moves the FSM to COPY on the next edge.
  - COPY copies shadow channel idx to live, idx = 0..NCH-1, one per cycle, then returns to IDLE and increments commit_cnt (wraps at 16 bits).
  - wr_busy = 1 exactly while in COPY: NCH cycles, starting the cycle after the commit write.
- Write while busy: any wr_en while wr_busy is ignored entirely, including global and CTRL writes. A commit request while in COPY is dropped.
- Reads during COPY are permitted and return shadow and status.
- tx_cnt: 32-bit, saturates at 32'hFFFFFFFF. If a clear and a tx_pulse occur in the same cycle, the counter becomes 1.
- Read pipeline:
  - RD_LAT=1: rd_data is registered from rd_addr, valid the edge after.
  - RD_LAT=2: one extra output register stage.
  - A read and a write to the same offset in the same cycle returns the pre-write value.
- Reset values (async assert, all registers):
  - if_v4addr 10.0.21.199; if_macaddr 48'h003776_000001.
  - Every channel, both shadow and live: dest_v4addr 10.0.21.255, dest_macaddr 48'hFFFF_FFFF_FFFF, paddr[47:12] 36'h0_000D_0000.
  - tx_cnt 0; commit_cnt 0; FSM IDLE; wr_busy 0; rd_data 0.
- Reset asserted mid-COPY: aborts immediately; all live values return to reset values.

Test Plan:
- Reset, then read offsets 0x1000, 0x1002, 0x1003 (debug=8'h5A) and 0x1004 -> 0x0A0015C7, 0x00377600, 0x0001005A, 0x02000004 (NCH=4).
- Write ch2 +0 = 0xC0A80101 (be=4'hF) -> shadow readback 0xC0A80101 and live dest_v4addr[95:64] still 0x0A0015FF. Then commit -> wr_busy high 4 cycles, live = 0xC0A80101, STATUS = 0x00010000.
- Partial write: ch0 +2, be=4'b0010, data 0x00AB0000 -> mac shadow 48'hFFAB_FFFF_FFFF.
- During COPY, write 0x1000 = 0x01020304 -> ignored, if_v4addr unchanged. Second commit during COPY -> commit_cnt increments once only.
- tx_pulse[1] 3 times, then clear write to ch1 +6 coincident with a pulse -> reads 3, then 1. Preload near max -> saturates at 0xFFFFFFFF.
- RD_LAT=2 build: read 0x1004 -> data appears exactly 2 edges later. Assert sys_rst_n low mid-COPY -> wr_busy drops at once, live outputs back at reset values.
